// File: rtl/pulse_width_meter.sv
// Measures high-time between rise/fall edge events and holds the result until the consumer accepts it.
// Optional glitch rejection of pulses shorter than MIN_WIDTH when PWM_MIN_FILTER_EN is defined.
module pulse_width_meter #(
  parameter int CNT_W     = 16,
  parameter int MIN_WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rise_i,
  input  logic             fall_i,
  input  logic             ready_i,
  output logic [CNT_W-1:0] width_o,
  output logic             ovf_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             overrun_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEAS = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic             ovf_q, ovf_d;
  logic             overrun_q, overrun_d;

`ifdef PWM_MIN_FILTER_EN
  localparam logic [CNT_W-1:0] MIN_W = CNT_W'(MIN_WIDTH);
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    width_d   = width_q;
    ovf_d     = ovf_q;
    overrun_d = overrun_q;
    case (state_q)
      IDLE: begin
        if (rise_i) begin
          state_d = MEAS;
          cnt_d   = CNT_ONE;
          sat_d   = 1'b0;
        end
      end
      MEAS: begin
        if (fall_i) begin
`ifdef PWM_MIN_FILTER_EN
          if (cnt_q < MIN_W) begin
            state_d = IDLE;
          end else begin
            width_d = cnt_q;
            ovf_d   = sat_q;
            state_d = HOLD;
          end
`else
          width_d = cnt_q;
          ovf_d   = sat_q;
          state_d = HOLD;
`endif
        end else if (rise_i) begin
          cnt_d = CNT_ONE;
          sat_d = 1'b0;
        end else begin
          // saturate rather than wrap; sat flag latches once the ceiling is hit
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
          sat_d = sat_q | (cnt_d == CNT_MAX);
        end
      end
      HOLD: begin
        if (ready_i) begin
          if (rise_i) begin
            state_d = MEAS;
            cnt_d   = CNT_ONE;
            sat_d   = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else if (rise_i) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
      width_q   <= '0;
      ovf_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
      width_q   <= width_d;
      ovf_q     <= ovf_d;
      overrun_q <= overrun_d;
    end
  end

  assign width_o   = width_q;
  assign ovf_o     = ovf_q;
  assign valid_o   = (state_q == HOLD);
  assign busy_o    = (state_q == MEAS);
  assign overrun_o = overrun_q;

endmodule

// File: doc/pulse_width_meter.md
PULSE_WIDTH_METER -- requirements
Module: pulse_width_meter

Interface
REQ-001 Parameter CNT_W, default 16, width of the measurement counter and of width_o.
REQ-002 Parameter MIN_WIDTH, default 2, minimum reportable pulse width in cycles; used only when PWM_MIN_FILTER_EN is defined.
REQ-003 clk  input  1  clock; all state SHALL update on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rise_i  input  1  single-cycle rising-edge event from the upstream edge-detect stage.
REQ-006 fall_i  input  1  single-cycle falling-edge event from the upstream edge-detect stage.
REQ-007 width_o  output  CNT_W  measured high-time in clk cycles; meaningful only while valid_o=1.
REQ-008 ovf_o  output  1  width_o saturated; qualified by valid_o.
REQ-009 valid_o  output  1  measurement available.
REQ-010 ready_i  input  1  consumer accepts the measurement when valid_o && ready_i.
REQ-011 busy_o  output  1  high while state is MEAS.
REQ-012 overrun_o  output  1  sticky; a rise_i was lost while a result was held.

Function
REQ-013 FSM states IDLE, MEAS, HOLD; reset state IDLE.
REQ-014 IDLE: rise_i -> MEAS with count=1; fall_i ignored; rise_i and fall_i together are treated as rise_i only.
REQ-015 MEAS, fall_i=1: width_o<=count, ovf_o<=sat flag, -> HOLD; valid_o high from the next cycle.
REQ-016 MEAS, fall_i=0, rise_i=1: restart with count=1 and sat flag cleared; no result is emitted.
REQ-017 MEAS, neither event: count<=count+1, saturating at 2^CNT_W-1; the sat flag SHALL be set once the count reaches 2^CNT_W-1.
REQ-018 MEAS, fall_i and rise_i together: fall_i wins and rise_i is ignored.
REQ-019 Width definition: rise_i in cycle t and fall_i in cycle t+N SHALL give width_o=N (N>=1).
REQ-020 HOLD: valid_o=1; width_o and ovf_o stable until handshake; valid_o SHALL NOT drop without ready_i.
REQ-021 HOLD, valid_o && ready_i, no rise_i: -> IDLE.
REQ-022 HOLD, valid_o && ready_i && rise_i: -> MEAS with count=1 (zero-bubble restart).
REQ-023 HOLD, rise_i without ready_i: the event is dropped and overrun_o is set; overrun_o is cleared only by reset.
REQ-024 fall_i in HOLD SHALL be ignored.
REQ-025 busy_o SHALL equal (state==MEAS); valid_o SHALL equal (state==HOLD); all outputs registered.

Reset
REQ-026 reset SHALL force: state=IDLE, count=0, width_o=0, ovf_o=0, valid_o=0, busy_o=0, overrun_o=0.
REQ-027 reset asserted mid-MEAS or mid-HOLD SHALL discard the measurement with no valid_o pulse; reset takes priority over all inputs in the same cycle.

Configuration
REQ-028 Macro PWM_MIN_FILTER_EN defined: on fall_i in MEAS with count<MIN_WIDTH, the FSM SHALL go to IDLE without asserting valid_o (glitch rejected); pulses with count>=MIN_WIDTH are reported normally.
REQ-029 Macro PWM_MIN_FILTER_EN undefined: every pulse of width>=1 SHALL be reported; MIN_WIDTH has no effect.

Verification
REQ-030 rise_i@t, fall_i@t+5, ready_i=1 -> valid_o=1 at t+6, width_o=5, ovf_o=0; IDLE at t+7.
REQ-031 CNT_W=4, rise_i then fall_i 20 cycles later -> width_o=15, ovf_o=1.
REQ-032 Result held with ready_i=0 for 10 cycles; rise_i during hold -> width_o stable, overrun_o=1, no new measurement; ready_i=1 -> IDLE.
REQ-033 HOLD with ready_i=1 and rise_i in same cycle, fall_i 3 cycles later -> second result width_o=3, no lost event, overrun_o=0.
REQ-034 reset in 3rd cycle of MEAS, fall_i afterwards -> valid_o stays 0, all outputs 0.
REQ-035 PWM_MIN_FILTER_EN, MIN_WIDTH=2: width-1 pulse -> no valid_o; width-2 pulse -> width_o=2. Macro undefined: width-1 pulse -> width_o=1.
